// File: rtl/memory_read_router.sv
// memory_read_router
//
// N-way read router in front of the single shared instruction-memory read
// port. Requesters are served by round-robin arbitration, optionally with
// requester N_REQ-1 (the character-class fetch port) as a strict-priority
// port. Each accepted read pushes its requester id into a fixed-latency tag
// pipeline so the returning memory data is flagged only for the requester
// that issued it. Each requester may have at most MAX_OUTSTANDING reads in
// flight.
//
// Ports
//   clk         clock
//   rst         synchronous active-high reset
//   req_valid   per-requester read request
//   req_addr    per-requester address, slot i at [i*MEMORY_ADDR_WIDTH +: MEMORY_ADDR_WIDTH]
//   req_ready   request accepted this cycle (one-hot or zero)
//   resp_valid  read data valid for requester i (one-hot or zero)
//   resp_data   read data, every slot carries the memory data
//   mem_valid   request to memory
//   mem_addr    memory address
//   mem_ready   memory accepts the request
//   mem_data    memory data, MEM_LATENCY cycles after acceptance
//
// Build option
//   MEM_ROUTER_RESP_REG_EN  registers resp_valid/resp_data (+1 cycle latency);
//                           the outstanding count is released at the
//                           registered output. Undefined: the response is
//                           combinational from the last tag stage.

module memory_read_router #(
    parameter int N_REQ             = 5,
    parameter int MEMORY_ADDR_WIDTH = 11,
    parameter int MEMORY_WIDTH      = 16,
    parameter int MEM_LATENCY       = 1,
    parameter int MAX_OUTSTANDING   = 2,
    parameter int PRIO_LAST         = 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [N_REQ-1:0]                     req_valid,
    input  logic [N_REQ*MEMORY_ADDR_WIDTH-1:0]   req_addr,
    output logic [N_REQ-1:0]                     req_ready,
    output logic [N_REQ-1:0]                     resp_valid,
    output logic [N_REQ*MEMORY_WIDTH-1:0]        resp_data,
    output logic                                 mem_valid,
    output logic [MEMORY_ADDR_WIDTH-1:0]         mem_addr,
    input  logic                                 mem_ready,
    input  logic [MEMORY_WIDTH-1:0]              mem_data
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int RR_N  = (PRIO_LAST != 0) ? N_REQ - 1 : N_REQ;
    localparam int LAST  = MEM_LATENCY - 1;

    localparam logic [PTR_W-1:0] RR_LAST = PTR_W'(RR_N - 1);
    localparam logic [PTR_W-1:0] PRIO_ID = PTR_W'(N_REQ - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
    logic             tag_vld_q [MEM_LATENCY];
    logic             tag_vld_d [MEM_LATENCY];
    logic [PTR_W-1:0] tag_id_q  [MEM_LATENCY];
    logic [PTR_W-1:0] tag_id_d  [MEM_LATENCY];
    logic [CNT_W-1:0] out_cnt_q [N_REQ];
    logic [CNT_W-1:0] out_cnt_d [N_REQ];

    logic [N_REQ-1:0] elig;
    logic [N_REQ-1:0] tag_hit;
    logic [N_REQ-1:0] rsp_dec;
    logic [PTR_W-1:0] grant_id;
    logic             xfer;
    logic             prio_grant;

    // A requester sitting at the limit is still eligible in the cycle its
    // response retires, since that response frees the slot it needs.
    always_comb begin
        elig = '0;
        for (int i = 0; i < N_REQ; i++) begin
            elig[i] = ~rst & req_valid[i] & ((out_cnt_q[i] != CNT_MAX) | rsp_dec[i]);
        end
    end

    // Round-robin pick: the second pass (indices at/after the pointer)
    // overrides the first (indices before it), and each pass walks downward
    // so the lowest qualifying index wins -- i.e. first eligible at or after
    // rr_ptr, wrapping.
    always_comb begin
        grant_id   = '0;
        prio_grant = 1'b0;
        for (int i = RR_N - 1; i >= 0; i--) begin
            if (elig[i] && (PTR_W'(i) < rr_ptr_q)) grant_id = PTR_W'(i);
        end
        for (int i = RR_N - 1; i >= 0; i--) begin
            if (elig[i] && (PTR_W'(i) >= rr_ptr_q)) grant_id = PTR_W'(i);
        end
        if ((PRIO_LAST != 0) && elig[N_REQ-1]) begin
            grant_id   = PRIO_ID;
            prio_grant = 1'b1;
        end
    end

    assign mem_valid = |elig;
    assign xfer      = mem_valid & mem_ready;

    always_comb begin
        mem_addr  = '0;
        req_ready = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (mem_valid && (grant_id == PTR_W'(i))) begin
                mem_addr     = req_addr[i*MEMORY_ADDR_WIDTH +: MEMORY_ADDR_WIDTH];
                req_ready[i] = mem_ready;
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (xfer && !prio_grant) begin
            rr_ptr_d = (grant_id == RR_LAST) ? '0 : grant_id + 1'b1;
        end
    end

    // Tag pipeline shifts every cycle regardless of mem_ready; an idle
    // cycle simply inserts an invalid tag.
    always_comb begin
        for (int s = 0; s < MEM_LATENCY; s++) begin
            tag_vld_d[s] = 1'b0;
            tag_id_d[s]  = '0;
        end
        tag_vld_d[0] = xfer;
        tag_id_d[0]  = grant_id;
        for (int s = 1; s < MEM_LATENCY; s++) begin
            tag_vld_d[s] = tag_vld_q[s-1];
            tag_id_d[s]  = tag_id_q[s-1];
        end
    end

    always_comb begin
        tag_hit = '0;
        for (int i = 0; i < N_REQ; i++) begin
            tag_hit[i] = ~rst & tag_vld_q[LAST] & (tag_id_q[LAST] == PTR_W'(i));
        end
    end

`ifdef MEM_ROUTER_RESP_REG_EN
    logic [N_REQ-1:0]              resp_valid_q, resp_valid_d;
    logic [N_REQ*MEMORY_WIDTH-1:0] resp_data_q, resp_data_d;

    always_comb begin
        resp_valid_d = tag_hit;
        resp_data_d  = resp_data_q;
        if (|tag_hit) resp_data_d = {N_REQ{mem_data}};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid_q <= '0;
            resp_data_q  <= '0;
        end else begin
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign rsp_dec    = resp_valid_q;
`else
    assign resp_valid = tag_hit;
    assign resp_data  = {N_REQ{mem_data}};
    assign rsp_dec    = tag_hit;
`endif

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            out_cnt_d[i] = out_cnt_q[i];
            if (req_ready[i] && !rsp_dec[i]) begin
                out_cnt_d[i] = out_cnt_q[i] + 1'b1;
            end else if (rsp_dec[i] && !req_ready[i]) begin
                out_cnt_d[i] = out_cnt_q[i] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= '0;
            for (int s = 0; s < MEM_LATENCY; s++) begin
                tag_vld_q[s] <= 1'b0;
                tag_id_q[s]  <= '0;
            end
            for (int i = 0; i < N_REQ; i++) begin
                out_cnt_q[i] <= '0;
            end
        end else begin
            rr_ptr_q <= rr_ptr_d;
            for (int s = 0; s < MEM_LATENCY; s++) begin
                tag_vld_q[s] <= tag_vld_d[s];
                tag_id_q[s]  <= tag_id_d[s];
            end
            for (int i = 0; i < N_REQ; i++) begin
                out_cnt_q[i] <= out_cnt_d[i];
            end
        end
    end

    // Counter overflow/underflow would mean the eligibility gate or the
    // tag pipeline lost track of a read.
    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (req_ready[i] && !rsp_dec[i]) assert (out_cnt_q[i] != CNT_MAX);
                if (rsp_dec[i] && !req_ready[i]) assert (out_cnt_q[i] != '0);
            end
        end
    end

endmodule

// File: tb/tb_memory_read_router.sv
`timescale 1ns/1ps
module tb_memory_read_router;

    localparam int N   = 4;
    localparam int AW  = 11;
    localparam int DW  = 16;
    localparam int LAT = 2;
`ifdef MEM_ROUTER_RESP_REG_EN
    localparam int RESP_LAT = LAT + 1;
    localparam logic [5:0] LIM_MAIN = 6'b011011;
    localparam logic [5:0] LIM_M1   = 6'b001001;
`else
    localparam int RESP_LAT = LAT;
    localparam logic [5:0] LIM_MAIN = 6'b111111;
    localparam logic [5:0] LIM_M1   = 6'b010101;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N*AW-1:0] req_addr;
    logic            mem_ready;

    logic [N-1:0]    req_ready,  resp_valid;
    logic [N*DW-1:0] resp_data;
    logic            mem_valid;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_data, md_a;

    logic [N-1:0]    req_ready1, resp_valid1;
    logic [N*DW-1:0] resp_data1;
    logic            mem_valid1;
    logic [AW-1:0]   mem_addr1;
    logic [DW-1:0]   mem_data1, md1_a;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    memory_read_router #(
        .N_REQ(N), .MEMORY_ADDR_WIDTH(AW), .MEMORY_WIDTH(DW),
        .MEM_LATENCY(LAT), .MAX_OUTSTANDING(2), .PRIO_LAST(1)
    ) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_data(resp_data),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_ready(mem_ready),
        .mem_data(mem_data)
    );

    // Second instance with a single outstanding slot makes the limit visible.
    memory_read_router #(
        .N_REQ(N), .MEMORY_ADDR_WIDTH(AW), .MEMORY_WIDTH(DW),
        .MEM_LATENCY(LAT), .MAX_OUTSTANDING(1), .PRIO_LAST(1)
    ) dut_m1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(req_ready1), .resp_valid(resp_valid1), .resp_data(resp_data1),
        .mem_valid(mem_valid1), .mem_addr(mem_addr1), .mem_ready(mem_ready),
        .mem_data(mem_data1)
    );

    // Memory models: data = addr + 0x100, two cycles after acceptance.
    always @(posedge clk) begin
        md_a      <= (mem_valid && mem_ready) ? ({5'b0, mem_addr} + 16'h0100) : 16'hdead;
        mem_data  <= md_a;
        md1_a     <= (mem_valid1 && mem_ready) ? ({5'b0, mem_addr1} + 16'h0100) : 16'hdead;
        mem_data1 <= md1_a;
    end

    function automatic logic [AW-1:0] exp_addr(input int i);
        case (i)
            0: return 11'h012;
            1: return 11'h234;
            2: return 11'h456;
            default: return 11'h7ab;
        endcase
    endfunction

    function automatic logic [DW-1:0] exp_rdata(input int i);
        case (i)
            0: return 16'h0112;
            1: return 16'h0334;
            2: return 16'h0556;
            default: return 16'h08ab;
        endcase
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 4'b1111;
        mem_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            total++;
            if (req_ready !== 4'b0000) begin bad++; $display("FAIL rst_req_ready: got %b want 0000", req_ready); end
            total++;
            if (mem_valid !== 1'b0) begin bad++; $display("FAIL rst_mem_valid: got %b want 0", mem_valid); end
            total++;
            if (resp_valid !== 4'b0000) begin bad++; $display("FAIL rst_resp_valid: got %b want 0000", resp_valid); end
        end
        rst = 1'b0;
        #1;
        total++;
        if (req_ready !== 4'b1000) begin bad++; $display("FAIL rst_first_grant: got %b want 1000", req_ready); end
        total++;
        if (mem_addr !== 11'h7ab) begin bad++; $display("FAIL rst_first_addr: got %h want 7ab", mem_addr); end
        total++;
        if (dut.rr_ptr_q !== 2'd0) begin bad++; $display("FAIL rst_rr_ptr: got %0d want 0", dut.rr_ptr_q); end
        for (int i = 0; i < N; i++) begin
            total++;
            if (dut.out_cnt_q[i] !== 2'd0) begin bad++; $display("FAIL rst_out_cnt%0d: got %0d want 0", i, dut.out_cnt_q[i]); end
        end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp_g, exp_r;
        int k;
        do_reset();
        req_valid = 4'b0111;
        mem_ready = 1'b1;
        for (int c = 0; c < 9; c++) begin
            #1;
            exp_g = 4'b0001 << (c % 3);
            total++;
            if (req_ready !== exp_g) begin bad++; $display("FAIL rr_grant c%0d: got %b want %b", c, req_ready, exp_g); end
            total++;
            if (mem_addr !== exp_addr(c % 3)) begin bad++; $display("FAIL rr_addr c%0d: got %h want %h", c, mem_addr, exp_addr(c % 3)); end
            k = (c - RESP_LAT) % 3;
            exp_r = (c >= RESP_LAT) ? (4'b0001 << k) : 4'b0000;
            total++;
            if (resp_valid !== exp_r) begin bad++; $display("FAIL rr_resp_valid c%0d: got %b want %b", c, resp_valid, exp_r); end
            if (c >= RESP_LAT) begin
                total++;
                if (resp_data[k*DW +: DW] !== exp_rdata(k)) begin
                    bad++; $display("FAIL rr_resp_data c%0d: got %h want %h", c, resp_data[k*DW +: DW], exp_rdata(k));
                end
            end
            @(negedge clk);
        end
        req_valid = '0;
    endtask

    task automatic test_outstanding_limit();
        logic [N-1:0] exp_main, exp_m1;
        do_reset();
        req_valid = 4'b0010;
        mem_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1;
            exp_main = LIM_MAIN[c] ? 4'b0010 : 4'b0000;
            exp_m1   = LIM_M1[c]   ? 4'b0010 : 4'b0000;
            total++;
            if (req_ready !== exp_main) begin bad++; $display("FAIL lim2_grant c%0d: got %b want %b", c, req_ready, exp_main); end
            total++;
            if (req_ready1 !== exp_m1) begin bad++; $display("FAIL lim1_grant c%0d: got %b want %b", c, req_ready1, exp_m1); end
            if (c == 2) begin
                total++;
                if (dut.out_cnt_q[1] !== 2'd2) begin bad++; $display("FAIL lim2_cnt: got %0d want 2", dut.out_cnt_q[1]); end
            end
            if (c == RESP_LAT) begin
                total++;
                if (resp_valid1 !== 4'b0010) begin bad++; $display("FAIL lim1_resp_valid: got %b want 0010", resp_valid1); end
                total++;
                if (resp_data1[1*DW +: DW] !== 16'h0334) begin bad++; $display("FAIL lim1_resp_data: got %h want 0334", resp_data1[1*DW +: DW]); end
            end
            @(negedge clk);
        end
        req_valid = '0;
    endtask

    task automatic test_backpressure();
        do_reset();
        req_valid = 4'b0011;
        mem_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            total++;
            if (mem_valid !== 1'b1) begin bad++; $display("FAIL bp_mem_valid c%0d: got %b want 1", c, mem_valid); end
            total++;
            if (mem_addr !== 11'h012) begin bad++; $display("FAIL bp_addr c%0d: got %h want 012", c, mem_addr); end
            total++;
            if (req_ready !== 4'b0000) begin bad++; $display("FAIL bp_ready c%0d: got %b want 0000", c, req_ready); end
            total++;
            if (dut.rr_ptr_q !== 2'd0) begin bad++; $display("FAIL bp_rr_ptr c%0d: got %0d want 0", c, dut.rr_ptr_q); end
            @(negedge clk);
        end
        mem_ready = 1'b1;
        #1;
        total++;
        if (req_ready !== 4'b0001) begin bad++; $display("FAIL bp_release: got %b want 0001", req_ready); end
        @(negedge clk); #1;
        total++;
        if (req_ready !== 4'b0010) begin bad++; $display("FAIL bp_next: got %b want 0010", req_ready); end
        total++;
        if (dut.rr_ptr_q !== 2'd1) begin bad++; $display("FAIL bp_rr_adv: got %0d want 1", dut.rr_ptr_q); end
        req_valid = '0;
    endtask

    task automatic test_reset_midflight();
        do_reset();
        req_valid = 4'b0001;
        mem_ready = 1'b1;
        #1;
        total++;
        if (req_ready !== 4'b0001) begin bad++; $display("FAIL mid_xfer: got %b want 0001", req_ready); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if (mem_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_mem_valid: got %b want 0", mem_valid); end
        total++;
        if (resp_valid !== 4'b0000) begin bad++; $display("FAIL mid_resp_c1: got %b want 0000", resp_valid); end
        @(negedge clk);
        rst = 1'b0;
        req_valid = '0;
        #1;
        total++;
        if (resp_valid !== 4'b0000) begin bad++; $display("FAIL mid_resp_c2: got %b want 0000", resp_valid); end
        for (int i = 0; i < N; i++) begin
            total++;
            if (dut.out_cnt_q[i] !== 2'd0) begin bad++; $display("FAIL mid_out_cnt%0d: got %0d want 0", i, dut.out_cnt_q[i]); end
        end
        @(negedge clk); #1;
        total++;
        if (resp_valid !== 4'b0000) begin bad++; $display("FAIL mid_resp_c3: got %b want 0000", resp_valid); end
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_addr  = {11'h7ab, 11'h456, 11'h234, 11'h012};
        mem_ready = 1'b0;
        test_reset();
        test_round_robin();
        test_outstanding_limit();
        test_backpressure();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
